// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the DATA_MEM three-master arbiter.
// State encoding, master IDs and the address range check live here.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_CPU  = 2'd1;
    localparam logic [1:0] ID_CONV = 2'd2;
    localparam logic [1:0] ID_DP   = 2'd3;

    // Any set bit above the word-index field means the address misses DATA_MEM.
    function automatic logic addr_out_of_range(
        input logic [31:0] addr,
        input int unsigned aw
    );
        return (addr >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Saturating starvation counter for one DSP master.
// Clear wins over increment; o_at_limit flags the starved condition.
module dm_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    logic [3:0] r_cnt;
    logic       w_at_limit;

    assign w_at_limit = (r_cnt == 4'(LIMIT));
    assign o_at_limit = w_at_limit;

    // Count lost arbitrations, holding at LIMIT until the next grant.
    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && !w_at_limit) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Serialises CPU, CONV and DP req/ack transactions onto DATA_MEM.
// CPU has priority; each DSP is promoted once its starvation counter saturates.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    output logic                  cpu_ack_o,
    output logic [31:0]           cpu_rdata_o,
    input  logic                  conv_req_i,
    input  logic                  conv_we_i,
    input  logic [31:0]           conv_addr_i,
    input  logic [31:0]           conv_wdata_i,
    output logic                  conv_ack_o,
    output logic [31:0]           conv_rdata_o,
    input  logic                  dp_req_i,
    input  logic                  dp_we_i,
    input  logic [31:0]           dp_addr_i,
    input  logic [31:0]           dp_wdata_i,
    output logic                  dp_ack_o,
    output logic [31:0]           dp_rdata_o,
    output logic [ADDR_WIDTH-1:0] dm_addr_o,
    output logic [31:0]           dm_wdata_o,
    output logic                  dm_we_o,
    input  logic [31:0]           dm_rdata_i,
    output logic [1:0]            grant_o,
    output logic                  err_o
);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_we;
    logic                  r_oor;
    logic [1:0]            r_id;
    logic                  r_rr_dp;
    logic                  r_err;

    logic [1:0]            w_win;
    logic [1:0]            w_dsp_rr;
    logic                  w_decide;
    logic                  w_conv_lim;
    logic                  w_dp_lim;
    logic                  w_conv_st;
    logic                  w_dp_st;
    logic                  w_any_req;
    logic                  w_sel_we;
    logic [31:0]           w_sel_addr;
    logic [31:0]           w_sel_wdata;

    assign w_any_req = cpu_req_i | conv_req_i | dp_req_i;
    assign w_conv_st = conv_req_i & w_conv_lim;
    assign w_dp_st   = dp_req_i & w_dp_lim;
    assign w_dsp_rr  = r_rr_dp ? ID_DP : ID_CONV;
    assign w_decide  = (r_state == IDLE) && (w_win != ID_NONE);
    assign err_o     = r_err;

    dm_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_conv_ctr (
        .clock      (clock),
        .reset      (reset),
        .i_inc      (w_decide && conv_req_i && (w_win != ID_CONV)),
        .i_clr      (w_decide && (w_win == ID_CONV)),
        .o_at_limit (w_conv_lim)
    );

    dm_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_dp_ctr (
        .clock      (clock),
        .reset      (reset),
        .i_inc      (w_decide && dp_req_i && (w_win != ID_DP)),
        .i_clr      (w_decide && (w_win == ID_DP)),
        .o_at_limit (w_dp_lim)
    );

    // Winner: starved DSPs first, then CPU, then DSPs by round-robin.
    always_comb begin
        w_win = ID_NONE;
        if (w_conv_st && w_dp_st) begin
            w_win = w_dsp_rr;
        end else if (w_conv_st) begin
            w_win = ID_CONV;
        end else if (w_dp_st) begin
            w_win = ID_DP;
        end else if (cpu_req_i) begin
            w_win = ID_CPU;
        end else if (conv_req_i && dp_req_i) begin
            w_win = w_dsp_rr;
        end else if (conv_req_i) begin
            w_win = ID_CONV;
        end else if (dp_req_i) begin
            w_win = ID_DP;
        end
    end

    // Route the winning master's request fields toward the capture registers.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = 32'd0;
        w_sel_wdata = 32'd0;
        case (w_win)
            ID_CPU: begin
                w_sel_we    = cpu_we_i;
                w_sel_addr  = cpu_addr_i;
                w_sel_wdata = cpu_wdata_i;
            end
            ID_CONV: begin
                w_sel_we    = conv_we_i;
                w_sel_addr  = conv_addr_i;
                w_sel_wdata = conv_wdata_i;
            end
            ID_DP: begin
                w_sel_we    = dp_we_i;
                w_sel_addr  = dp_addr_i;
                w_sel_wdata = dp_wdata_i;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: fixed IDLE -> ACCESS -> ACK walk once a request is seen.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any_req ? ACCESS : IDLE;
            ACCESS:  w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Capture the granted transaction, the read data and the sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_waddr <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_id    <= ID_NONE;
            r_rr_dp <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_decide) begin
                r_waddr <= w_sel_addr[ADDR_WIDTH+1:2];
                r_wdata <= w_sel_wdata;
                r_we    <= w_sel_we;
                r_oor   <= addr_out_of_range(w_sel_addr, ADDR_WIDTH);
                r_id    <= w_win;
                if (w_win == ID_CONV) begin
                    r_rr_dp <= 1'b1;
                end else if (w_win == ID_DP) begin
                    r_rr_dp <= 1'b0;
                end
            end
            if (r_state == ACCESS) begin
                r_rdata <= (r_we || r_oor) ? 32'd0 : dm_rdata_i;
                if (r_oor) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Outputs: memory port in ACCESS, ack and data to the owner in ACK.
    // The write strobe is masked by reset so an aborted write never lands.
    always_comb begin
        dm_addr_o    = '0;
        dm_wdata_o   = 32'd0;
        dm_we_o      = 1'b0;
        grant_o      = ID_NONE;
        cpu_ack_o    = 1'b0;
        conv_ack_o   = 1'b0;
        dp_ack_o     = 1'b0;
        cpu_rdata_o  = 32'd0;
        conv_rdata_o = 32'd0;
        dp_rdata_o   = 32'd0;
        case (r_state)
            ACCESS: begin
                dm_addr_o  = r_waddr;
                dm_wdata_o = r_wdata;
                dm_we_o    = r_we & ~r_oor & ~reset;
                grant_o    = r_id;
            end
            ACK: begin
                grant_o = r_id;
                case (r_id)
                    ID_CPU: begin
                        cpu_ack_o   = 1'b1;
                        cpu_rdata_o = r_rdata;
                    end
                    ID_CONV: begin
                        conv_ack_o   = 1'b1;
                        conv_rdata_o = r_rdata;
                    end
                    ID_DP: begin
                        dp_ack_o   = 1'b1;
                        dp_rdata_o = r_rdata;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of arbitration and memory.
module tb_dm_arbiter;

    localparam int AW    = 8;
    localparam int LIMIT = 4;

    logic        clock;
    logic        reset;
    logic        cpu_req_i, conv_req_i, dp_req_i;
    logic        cpu_we_i, conv_we_i, dp_we_i;
    logic [31:0] cpu_addr_i, conv_addr_i, dp_addr_i;
    logic [31:0] cpu_wdata_i, conv_wdata_i, dp_wdata_i;
    logic        cpu_ack_o, conv_ack_o, dp_ack_o;
    logic [31:0] cpu_rdata_o, conv_rdata_o, dp_rdata_o;
    logic [AW-1:0] dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic        dm_we_o;
    logic [31:0] dm_rdata_i;
    logic [1:0]  grant_o;
    logic        err_o;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];

    bit          rq  [1:3];
    bit          wev [1:3];
    logic [31:0] ad  [1:3];
    logic [31:0] wd  [1:3];
    int          cnt [2:3];
    int          rr;
    bit          err_m;

    int checks = 0;
    int errors = 0;

    dm_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_ack_o    (cpu_ack_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .conv_req_i   (conv_req_i),
        .conv_we_i    (conv_we_i),
        .conv_addr_i  (conv_addr_i),
        .conv_wdata_i (conv_wdata_i),
        .conv_ack_o   (conv_ack_o),
        .conv_rdata_o (conv_rdata_o),
        .dp_req_i     (dp_req_i),
        .dp_we_i      (dp_we_i),
        .dp_addr_i    (dp_addr_i),
        .dp_wdata_i   (dp_wdata_i),
        .dp_ack_o     (dp_ack_o),
        .dp_rdata_o   (dp_rdata_o),
        .dm_addr_o    (dm_addr_o),
        .dm_wdata_o   (dm_wdata_o),
        .dm_we_o      (dm_we_o),
        .dm_rdata_i   (dm_rdata_i),
        .grant_o      (grant_o),
        .err_o        (err_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign dm_rdata_i = mem[dm_addr_o];

    always @(posedge clock) begin
        if (dm_we_o) mem[dm_addr_o] <= dm_wdata_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        cpu_req_i    = rq[1];
        cpu_we_i     = wev[1];
        cpu_addr_i   = ad[1];
        cpu_wdata_i  = wd[1];
        conv_req_i   = rq[2];
        conv_we_i    = wev[2];
        conv_addr_i  = ad[2];
        conv_wdata_i = wd[2];
        dp_req_i     = rq[3];
        dp_we_i      = wev[3];
        dp_addr_i    = ad[3];
        dp_wdata_i   = wd[3];
    endtask

    task automatic set_req(input int m, input bit we,
                           input logic [31:0] a, input logic [31:0] d);
        rq[m]  = 1'b1;
        wev[m] = we;
        ad[m]  = a;
        wd[m]  = d;
        drive();
    endtask

    task automatic clear_reqs();
        for (int m = 1; m <= 3; m++) rq[m] = 1'b0;
        drive();
    endtask

    task automatic model_reset();
        cnt[2] = 0;
        cnt[3] = 0;
        rr     = 2;
        err_m  = 1'b0;
    endtask

    // Who should win, from the priority rules over pending requests.
    function automatic int pick();
        int st[$];
        for (int d = 2; d <= 3; d++)
            if (rq[d] && cnt[d] >= LIMIT) st.push_back(d);
        if (st.size() == 2) return rr;
        if (st.size() == 1) return st[0];
        if (rq[1]) return 1;
        if (rq[2] && rq[3]) return rr;
        if (rq[2]) return 2;
        if (rq[3]) return 3;
        return 0;
    endfunction

    // Entered at a negedge in IDLE; returns at the negedge of the next IDLE.
    task automatic do_slot(input bit keep);
        int          w;
        logic [31:0] a;
        bit          oor;
        logic [7:0]  idx;
        logic [31:0] erd;
        logic [2:0]  eack;
        w = pick();
        if (w == 0) begin
            @(negedge clock);
            chk("idle_grant", 32'(grant_o), 32'd0);
            return;
        end
        a   = ad[w];
        oor = (a[31:10] != 22'd0);
        idx = a[9:2];
        for (int d = 2; d <= 3; d++) begin
            if (w == d) cnt[d] = 0;
            else if (rq[d] && cnt[d] < LIMIT) cnt[d]++;
        end
        if (w == 2) rr = 3;
        else if (w == 3) rr = 2;
        eack = (w == 1) ? 3'b100 : (w == 2) ? 3'b010 : 3'b001;
        erd  = (wev[w] || oor) ? 32'd0 : ref_mem[idx];
        if (oor) err_m = 1'b1;

        @(negedge clock);
        chk("acc_grant", 32'(grant_o), 32'(w));
        chk("acc_addr", 32'(dm_addr_o), 32'(idx));
        chk("acc_we", 32'(dm_we_o), 32'(wev[w] && !oor));
        chk("acc_wdata", dm_wdata_o, wd[w]);
        chk("acc_acks", 32'({cpu_ack_o, conv_ack_o, dp_ack_o}), 32'd0);

        @(negedge clock);
        chk("ack_grant", 32'(grant_o), 32'(w));
        chk("ack_vec", 32'({cpu_ack_o, conv_ack_o, dp_ack_o}), 32'(eack));
        chk("cpu_rdata", cpu_rdata_o, (w == 1) ? erd : 32'd0);
        chk("conv_rdata", conv_rdata_o, (w == 2) ? erd : 32'd0);
        chk("dp_rdata", dp_rdata_o, (w == 3) ? erd : 32'd0);
        chk("ack_we", 32'(dm_we_o), 32'd0);
        chk("err", 32'(err_o), 32'(err_m));
        if (wev[w] && !oor) ref_mem[idx] = wd[w];
        if (!keep) rq[w] = 1'b0;
        drive();

        @(negedge clock);
        chk("idle_grant", 32'(grant_o), 32'd0);
        chk("idle_acks", 32'({cpu_ack_o, conv_ack_o, dp_ack_o}), 32'd0);
        chk("idle_we", 32'(dm_we_o), 32'd0);
    endtask

    task automatic rand_reqs();
        logic [31:0] a;
        for (int m = 1; m <= 3; m++) begin
            if (!rq[m] && $urandom_range(0, 1) == 1) begin
                a = $urandom;
                if ($urandom_range(0, 9) == 0) a = a | 32'h0000_0400;
                else a = a & 32'h0000_03FF;
                set_req(m, 1'($urandom_range(0, 1)), a, $urandom);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        for (int m = 1; m <= 3; m++) begin
            rq[m]  = 1'b0;
            wev[m] = 1'b0;
            ad[m]  = 32'd0;
            wd[m]  = 32'd0;
        end
        model_reset();
        drive();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_acks", 32'({cpu_ack_o, conv_ack_o, dp_ack_o}), 32'd0);
        chk("rst_rdata", cpu_rdata_o | conv_rdata_o | dp_rdata_o, 32'd0);
        chk("rst_dm", 32'({dm_we_o, dm_addr_o}), 32'd0);
        chk("rst_wdata", dm_wdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);

        // CPU write then read back through word 4.
        set_req(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        do_slot(1'b0);
        set_req(1, 1'b0, 32'h0000_0010, 32'd0);
        do_slot(1'b0);

        // CONV and DP held: strict alternation.
        set_req(2, 1'b0, 32'h0000_0040, 32'd0);
        set_req(3, 1'b1, 32'h0000_0044, 32'h0BAD_F00D);
        for (int i = 0; i < 4; i++) do_slot(1'b1);
        clear_reqs();

        // All three, CPU hammering: starvation promotion.
        set_req(1, 1'b0, 32'h0000_0010, 32'd0);
        set_req(2, 1'b1, 32'h0000_0080, 32'h1111_2222);
        set_req(3, 1'b0, 32'h0000_0044, 32'd0);
        for (int i = 0; i < 8; i++) do_slot(1'b1);
        clear_reqs();

        // Out-of-range write, then error must stay sticky.
        set_req(2, 1'b1, 32'h0000_0400, 32'hCAFE_CAFE);
        do_slot(1'b0);
        set_req(1, 1'b0, 32'h0000_0080, 32'd0);
        do_slot(1'b0);

        // Reset during ACCESS of a DP write.
        set_req(3, 1'b1, 32'h0000_0020, 32'h1234_5678);
        do_slot(1'b0);
        set_req(3, 1'b1, 32'h0000_0020, 32'hBAD0_BAD0);
        @(negedge clock);
        chk("rw_grant", 32'(grant_o), 32'd3);
        reset = 1'b1;
        #1;
        chk("rw_we_masked", 32'(dm_we_o), 32'd0);
        clear_reqs();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        chk("rw_acks", 32'({cpu_ack_o, conv_ack_o, dp_ack_o}), 32'd0);
        chk("rw_grant0", 32'(grant_o), 32'd0);
        chk("rw_err", 32'(err_o), 32'd0);
        chk("rw_addr", 32'(dm_addr_o), 32'd0);
        @(negedge clock);
        chk("rw_dp_ack", 32'(dp_ack_o), 32'd0);
        set_req(1, 1'b0, 32'h0000_0020, 32'd0);
        do_slot(1'b0);

        // CPU read held across its ack: back-to-back transactions.
        set_req(1, 1'b0, 32'h0000_0010, 32'd0);
        do_slot(1'b1);
        do_slot(1'b0);

        // Random traffic.
        for (int i = 0; i < 120; i++) begin
            rand_reqs();
            do_slot(1'($urandom_range(0, 3) == 0));
        end
        clear_reqs();
        do_slot(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
